// File: rtl/bank_axi3_mem_slave.sv
// bank_axi3_mem_slave: AXI3 slave with DEPTH x DATA_WIDTH on-chip storage.
//   Independent read (R_IDLE/R_DATA) and write (W_IDLE/W_DATA/W_RESP) FSMs.
//   Word index = addr[ADDR_WIDTH-1:5]. INCR and other non-FIXED bursts step
//   the index modulo DEPTH; FIXED bursts keep it.
//   Ports: clk_i, rst_i (sync, active high), AR/R, AW/W/B channel groups.
//   Optional macro BANK_AXI3_SLV_RANGE_ERR_EN: bursts whose start index is
//   >= DEPTH answer SLVERR, read zero data and drop their writes. Without it
//   the index wraps modulo DEPTH and the response is always OKAY.
module bank_axi3_mem_slave #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 256,
   parameter int unsigned ID_WIDTH   = 6,
   parameter int unsigned DEPTH      = 64
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    slv_axi3_arvalid_i,
   output logic                    slv_axi3_arready_o,
   input  logic [ID_WIDTH-1:0]     slv_axi3_arid_i,
   input  logic [ADDR_WIDTH-1:0]   slv_axi3_araddr_i,
   input  logic [3:0]              slv_axi3_arlen_i,
   input  logic [2:0]              slv_axi3_arsize_i,
   input  logic [1:0]              slv_axi3_arburst_i,
   output logic                    slv_axi3_rvalid_o,
   input  logic                    slv_axi3_rready_i,
   output logic [ID_WIDTH-1:0]     slv_axi3_rid_o,
   output logic [DATA_WIDTH-1:0]   slv_axi3_rdata_o,
   output logic [1:0]              slv_axi3_rresp_o,
   output logic                    slv_axi3_rlast_o,
   input  logic                    slv_axi3_awvalid_i,
   output logic                    slv_axi3_awready_o,
   input  logic [ID_WIDTH-1:0]     slv_axi3_awid_i,
   input  logic [ADDR_WIDTH-1:0]   slv_axi3_awaddr_i,
   input  logic [3:0]              slv_axi3_awlen_i,
   input  logic [2:0]              slv_axi3_awsize_i,
   input  logic [1:0]              slv_axi3_awburst_i,
   input  logic                    slv_axi3_wvalid_i,
   output logic                    slv_axi3_wready_o,
   input  logic [ID_WIDTH-1:0]     slv_axi3_wid_i,
   input  logic [DATA_WIDTH-1:0]   slv_axi3_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] slv_axi3_wstrb_i,
   input  logic                    slv_axi3_wlast_i,
   output logic                    slv_axi3_bvalid_o,
   input  logic                    slv_axi3_bready_i,
   output logic [ID_WIDTH-1:0]     slv_axi3_bid_o,
   output logic [1:0]              slv_axi3_bresp_o
);

   localparam int unsigned IDX_W  = $clog2(DEPTH);
   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned OFS_W  = 5;
   localparam logic [1:0]  BURST_FIXED = 2'b00;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic       {R_IDLE, R_DATA}         r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   r_state_t r_state, r_state_nxt;
   w_state_t w_state, w_state_nxt;

   logic [ID_WIDTH-1:0] r_id, w_id;
   logic [IDX_W-1:0]    r_idx, w_idx;
   logic [3:0]          r_cnt, r_len;
   logic                r_fixed, w_fixed;
   logic                r_err, w_err;
   logic [1:0]          r_resp, w_resp;
   logic                ar_err, aw_err;
   logic                ar_hs, r_hs, aw_hs, w_hs, b_hs;

   // Start index beyond the storage only matters when range errors are enabled
`ifdef BANK_AXI3_SLV_RANGE_ERR_EN
   assign ar_err = |slv_axi3_araddr_i[ADDR_WIDTH-1:OFS_W+IDX_W];
   assign aw_err = |slv_axi3_awaddr_i[ADDR_WIDTH-1:OFS_W+IDX_W];
`else
   assign ar_err = 1'b0;
   assign aw_err = 1'b0;
`endif

   // Inputs that carry no meaning for this slave
   logic unused_bits;
   assign unused_bits = ^{slv_axi3_araddr_i[OFS_W-1:0], slv_axi3_awaddr_i[OFS_W-1:0],
                          slv_axi3_araddr_i[ADDR_WIDTH-1:OFS_W+IDX_W],
                          slv_axi3_awaddr_i[ADDR_WIDTH-1:OFS_W+IDX_W],
                          slv_axi3_arsize_i, slv_axi3_awsize_i, slv_axi3_awlen_i,
                          slv_axi3_wid_i};

   assign ar_hs = slv_axi3_arvalid_i & slv_axi3_arready_o;
   assign r_hs  = slv_axi3_rvalid_o  & slv_axi3_rready_i;
   assign aw_hs = slv_axi3_awvalid_i & slv_axi3_awready_o;
   assign w_hs  = slv_axi3_wvalid_i  & slv_axi3_wready_o;
   assign b_hs  = slv_axi3_bvalid_o  & slv_axi3_bready_i;

   // ---------------- read channel ----------------
   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= R_IDLE;
      else       r_state <= r_state_nxt;
   end

   // Next state
   always_comb begin
      r_state_nxt = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
         R_DATA:  if (r_hs && slv_axi3_rlast_o) r_state_nxt = R_IDLE;
         default: r_state_nxt = R_IDLE;
      endcase
   end

   // Outputs; rdata follows the latched index so it is stable under backpressure
   always_comb begin
      slv_axi3_arready_o = 1'b0;
      slv_axi3_rvalid_o  = 1'b0;
      slv_axi3_rlast_o   = 1'b0;
      slv_axi3_rdata_o   = '0;
      case (r_state)
         R_IDLE: slv_axi3_arready_o = 1'b1;
         R_DATA: begin
            slv_axi3_rvalid_o = 1'b1;
            slv_axi3_rlast_o  = (r_cnt == r_len);
            slv_axi3_rdata_o  = r_err ? '0 : mem[r_idx];
         end
         default: ;
      endcase
   end

   // Read burst context
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_id    <= '0;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_len   <= '0;
         r_fixed <= 1'b0;
         r_err   <= 1'b0;
         r_resp  <= RESP_OKAY;
      end else if (ar_hs) begin
         r_id    <= slv_axi3_arid_i;
         r_idx   <= slv_axi3_araddr_i[OFS_W +: IDX_W];
         r_cnt   <= '0;
         r_len   <= slv_axi3_arlen_i;
         r_fixed <= (slv_axi3_arburst_i == BURST_FIXED);
         r_err   <= ar_err;
         r_resp  <= ar_err ? RESP_SLVERR : RESP_OKAY;
      end else if (r_hs) begin
         r_cnt <= r_cnt + 4'd1;
         if (!r_fixed) r_idx <= r_idx + IDX_W'(1);
      end
   end

   assign slv_axi3_rid_o   = r_id;
   assign slv_axi3_rresp_o = r_resp;

   // ---------------- write channel ----------------
   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) w_state <= W_IDLE;
      else       w_state <= w_state_nxt;
   end

   // Next state; wlast alone closes the burst
   always_comb begin
      w_state_nxt = w_state;
      case (w_state)
         W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
         W_DATA:  if (w_hs && slv_axi3_wlast_i) w_state_nxt = W_RESP;
         W_RESP:  if (b_hs) w_state_nxt = W_IDLE;
         default: w_state_nxt = W_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      slv_axi3_awready_o = 1'b0;
      slv_axi3_wready_o  = 1'b0;
      slv_axi3_bvalid_o  = 1'b0;
      case (w_state)
         W_IDLE:  slv_axi3_awready_o = 1'b1;
         W_DATA:  slv_axi3_wready_o  = 1'b1;
         W_RESP:  slv_axi3_bvalid_o  = 1'b1;
         default: ;
      endcase
   end

   // Write burst context
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         w_id    <= '0;
         w_idx   <= '0;
         w_fixed <= 1'b0;
         w_err   <= 1'b0;
         w_resp  <= RESP_OKAY;
      end else if (aw_hs) begin
         w_id    <= slv_axi3_awid_i;
         w_idx   <= slv_axi3_awaddr_i[OFS_W +: IDX_W];
         w_fixed <= (slv_axi3_awburst_i == BURST_FIXED);
         w_err   <= aw_err;
         w_resp  <= aw_err ? RESP_SLVERR : RESP_OKAY;
      end else if (w_hs && !w_fixed) begin
         w_idx <= w_idx + IDX_W'(1);
      end
   end

   assign slv_axi3_bid_o   = w_id;
   assign slv_axi3_bresp_o = w_resp;

   // Byte-lane storage write; not reset, and suppressed while reset is held
   always_ff @(posedge clk_i) begin
      if (!rst_i && w_hs && !w_err) begin
         for (int unsigned b = 0; b < STRB_W; b++) begin
            if (slv_axi3_wstrb_i[b]) mem[w_idx][b*8 +: 8] <= slv_axi3_wdata_i[b*8 +: 8];
         end
      end
   end

endmodule

// File: doc/bank_axi3_mem_slave.md
BANK_AXI3_MEM_SLAVE -- requirements
Module: bank_axi3_mem_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 256: data beat width (32 bytes).
REQ-003 SHALL have parameter ID_WIDTH, default 6: AXI ID width.
REQ-004 SHALL have parameter DEPTH, default 64: number of DATA_WIDTH storage words (power of two).
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports as follows:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- slv_axi3_arvalid_i / slv_axi3_arready_o  in/out  1/1  AR handshake
- slv_axi3_arid_i  in  ID_WIDTH  read ID
- slv_axi3_araddr_i  in  ADDR_WIDTH  read byte address
- slv_axi3_arlen_i  in  4  beats minus one
- slv_axi3_arsize_i  in  3  ignored, fixed 32 bytes
- slv_axi3_arburst_i  in  2  burst type
- slv_axi3_rvalid_o / slv_axi3_rready_i  out/in  1/1  R handshake
- slv_axi3_rid_o  out  ID_WIDTH  echoed read ID
- slv_axi3_rdata_o  out  DATA_WIDTH  read data
- slv_axi3_rresp_o  out  2  read response
- slv_axi3_rlast_o  out  1  last read beat
- AW group: slv_axi3_awvalid_i, slv_axi3_awready_o, slv_axi3_awid_i, slv_axi3_awaddr_i, slv_axi3_awlen_i, slv_axi3_awsize_i, slv_axi3_awburst_i, mirroring the AR group.
- slv_axi3_wvalid_i / slv_axi3_wready_o  in/out  1/1  W handshake
- slv_axi3_wid_i  in  ID_WIDTH  ignored
- slv_axi3_wdata_i  in  DATA_WIDTH  write data
- slv_axi3_wstrb_i  in  DATA_WIDTH/8  byte enables
- slv_axi3_wlast_i  in  1  last write beat
- slv_axi3_bvalid_o / slv_axi3_bready_i  out/in  1/1  B handshake
- slv_axi3_bid_o  out  ID_WIDTH  echoed AW ID
- slv_axi3_bresp_o  out  2  write response

Function
REQ-006 Word index SHALL be addr[ADDR_WIDTH-1:5]; addr[4:0] SHALL be ignored.
REQ-007 Read FSM SHALL have states R_IDLE and R_DATA. arready=1 only in R_IDLE. On an AR handshake it SHALL latch id, index and len, clear the beat counter, and enter R_DATA.
REQ-008 In R_DATA, rvalid SHALL be 1 and rdata SHALL equal mem[cur_index], driven combinationally from the latched index. First beat is available on the cycle after the AR handshake.
REQ-009 On each R handshake: beat counter +1. Index +1 (4-bit-safe, wraps modulo DEPTH) for burst INCR (01) and all other non-FIXED values; index unchanged for FIXED (00).
REQ-010 rlast SHALL be 1 when beat counter equals latched len. An R handshake with rlast=1 SHALL return to R_IDLE.
REQ-011 While rvalid=1 and rready=0, rid/rdata/rresp/rlast SHALL stay stable.
REQ-012 Write FSM SHALL have states W_IDLE, W_DATA and W_RESP. awready=1 only in W_IDLE; an AW handshake latches id and index and enters W_DATA.
REQ-013 In W_DATA, wready=1. Each W handshake SHALL write byte lanes whose wstrb bit is 1 into mem[cur_index] at the clock edge, then advance the index per REQ-009.
REQ-014 A W handshake with wlast=1 SHALL enter W_RESP. wlast is trusted; awlen SHALL NOT be checked.
REQ-015 In W_RESP, bvalid=1 with bid = latched id. A B handshake SHALL return to W_IDLE.
REQ-016 Read and write FSMs SHALL run independently. A same-cycle read and write of the same word SHALL return the old data (read-before-write); the new data is visible from the next cycle.
REQ-017 rresp and bresp SHALL be OKAY (00) unless REQ-020 applies.

Reset
REQ-018 On rst_i=1 at a clock edge, both FSMs SHALL go idle, any in-flight burst SHALL be dropped, and the following SHALL clear: rvalid, rlast, bvalid, rid, bid, rresp, bresp; arready=1, awready=1, wready=0. Memory contents SHALL NOT be reset.
REQ-019 Reset asserted mid-burst SHALL produce no further R or B beats for that burst.

Configuration
REQ-020 Macro BANK_AXI3_SLV_RANGE_ERR_EN:
- Defined: a burst whose starting index is >= DEPTH SHALL return SLVERR (10) on every R beat with rdata=0, and on B. Its W beats SHALL be accepted but not written.
- Undefined: the index SHALL be taken modulo DEPTH and the response SHALL be OKAY.

Verification
REQ-021 AW addr 0x40, len 0; W data A, wstrb all-ones, wlast -> bvalid the cycle after the W handshake, bresp 00, bid = awid; then AR addr 0x40, len 0 -> rdata A, rlast=1, rresp 00.
REQ-022 Write 4-beat INCR at 0x0 with data 1,2,3,4; read 4-beat INCR at 0x0 holding rready=0 for 3 cycles on beat 2 -> beats 1,2,3,4 in order, beat 2 held stable, rlast only on beat 4.
REQ-023 Write wstrb=0x0000000F with data all-ones over a word holding 0 -> read returns 0x...0FFFFFFFF (only bytes 0-3 set).
REQ-024 FIXED read, len 3, at a word holding B -> four beats, all B.
REQ-025 Assert rst_i during beat 1 of a 4-beat read -> rvalid=0 the next cycle, arready=1, no further beats.
REQ-026 With the macro defined, AR addr DEPTH*32 -> rresp 10, rdata 0. With the macro undefined, same request -> data of word 0, rresp 00.
